// File: rtl/refill_word_buffer_if.sv
// Handshake bundle for refill_word_buffer: push strobe/data, flush, and the
// head-word consumer handshake plus occupancy status.
interface refill_word_buffer_if #(
    parameter int BLOCK_WIDTH = 32,
    parameter int DEPTH       = 4
);
    logic                     in_done;
    logic [BLOCK_WIDTH-1:0]   in_data;
    logic                     flush;
    logic                     buff_full;
    logic                     out_valid;
    logic [BLOCK_WIDTH-1:0]   out_data;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_done, in_data, flush, out_ready,
        input  buff_full, out_valid, out_data, count
    );

    modport slave (
        input  in_done, in_data, flush, out_ready,
        output buff_full, out_valid, out_data, count
    );
endinterface

// File: rtl/refill_word_buffer.sv
// Registered FIFO for refill words: no fall-through, full flag from state only.
// Optional sticky overflow flag via `define REFILL_BUF_ERR_FLAG_EN.
module refill_word_buffer #(
    parameter int BLOCK_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                clk,
    input  logic                rst,
    refill_word_buffer_if.slave bus
`ifdef REFILL_BUF_ERR_FLAG_EN
    ,
    output logic                err_overflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [BLOCK_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_valid = (r_count != '0);
    // Full is judged on the start-of-cycle count, so a pop never frees room for a same-cycle push.
    assign w_push  = bus.in_done & ~bus.flush & ~w_full;
    assign w_pop   = w_valid & bus.out_ready & ~bus.flush;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

`ifdef REFILL_BUF_ERR_FLAG_EN
    logic r_err_overflow;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_err_overflow <= 1'b0;
        end else if (bus.in_done && w_full) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign err_overflow = r_err_overflow;
`endif

    assign bus.buff_full = w_full;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_refill_word_buffer.sv
// Directed self-checking bench for refill_word_buffer (DEPTH=4, 32-bit words).
module tb_refill_word_buffer;
    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    refill_word_buffer_if #(.BLOCK_WIDTH(32), .DEPTH(4)) bus ();

`ifdef REFILL_BUF_ERR_FLAG_EN
    logic err_overflow;
    refill_word_buffer #(.BLOCK_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_overflow(err_overflow)
    );
`else
    refill_word_buffer #(.BLOCK_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic done, input logic [31:0] data, input logic rdy, input logic fl);
        bus.in_done   = done;
        bus.in_data   = data;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic push(input logic [31:0] data);
        drive(1'b1, data, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_err(input string tag, input logic exp);
`ifdef REFILL_BUF_ERR_FLAG_EN
        check(tag, {31'b0, err_overflow}, {31'b0, exp});
`else
        if (exp === 1'bx) $display("unused");
`endif
    endtask

    initial begin
        logic [31:0] exp_pop [6];
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(bus.count), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_data", bus.out_data, 0);
        check("rst_full", 32'(bus.buff_full), 0);
        check_err("rst_err", 1'b0);

        // Two pushes, no consumer
        drive(1'b1, 32'hA1, 1'b0, 1'b0);
        step();
        check("lat_valid", 32'(bus.out_valid), 1);
        check("lat_data", bus.out_data, 32'hA1);
        push(32'hB2);
        check("two_count", 32'(bus.count), 2);
        check("two_valid", 32'(bus.out_valid), 1);
        check("two_data", bus.out_data, 32'hA1);
        check("two_full", 32'(bus.buff_full), 0);

        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("flush_count", 32'(bus.count), 0);

        // Fill to DEPTH, then overflow
        push(32'h1);
        push(32'h2);
        push(32'h3);
        check("three_full", 32'(bus.buff_full), 0);
        push(32'h4);
        check("four_full", 32'(bus.buff_full), 1);
        check("four_count", 32'(bus.count), 4);
        check_err("four_err", 1'b0);
        push(32'h5);
        check("ovf_count", 32'(bus.count), 4);
        check_err("ovf_err", 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_%0d", i), bus.out_data, 32'(i));
            drive(1'b0, '0, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        check("drain_count", 32'(bus.count), 0);
        check("drain_valid", 32'(bus.out_valid), 0);
        check("drain_data", bus.out_data, 0);
        check_err("drain_err_sticky", 1'b1);

        // Empty pop has no effect
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("empty_pop_count", 32'(bus.count), 0);

        // Steady push+pop at count=2 across pointer wrap
        push(32'h10);
        push(32'h11);
        exp_pop = '{32'h10, 32'h11, 32'h70, 32'h71, 32'h72, 32'h73};
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wrap_head_%0d", i), bus.out_data, exp_pop[i]);
            drive(1'b1, 32'h70 + 32'(i), 1'b1, 1'b0);
            step();
            check($sformatf("wrap_count_%0d", i), 32'(bus.count), 2);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        check("wrap_head_end", bus.out_data, 32'h74);

        // Full + push + pop in one cycle: push dropped, pop taken
        push(32'h80);
        push(32'h81);
        check("full2_full", 32'(bus.buff_full), 1);
        drive(1'b1, 32'h9, 1'b1, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("fullpp_count", 32'(bus.count), 3);
        check("fullpp_full", 32'(bus.buff_full), 0);
        check("fullpp_head", bus.out_data, 32'h75);
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("fullpp_d1", bus.out_data, 32'h80);
        step();
        check("fullpp_d2", bus.out_data, 32'h81);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("fullpp_empty", 32'(bus.count), 0);

        // Push during flush on a 3-word buffer
        push(32'h21);
        push(32'h22);
        push(32'h23);
        drive(1'b1, 32'hC3, 1'b1, 1'b1);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("flushp_count", 32'(bus.count), 0);
        check("flushp_valid", 32'(bus.out_valid), 0);
        check("flushp_data", bus.out_data, 0);
        check_err("flushp_err", 1'b0);

        // Reset mid-stream with a concurrent push
        push(32'h31);
        push(32'h32);
        push(32'h33);
        rst = 1'b1;
        drive(1'b1, 32'h44, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("mrst_count", 32'(bus.count), 0);
        check("mrst_valid", 32'(bus.out_valid), 0);
        check("mrst_data", bus.out_data, 0);
        check("mrst_full", 32'(bus.buff_full), 0);
        push(32'hD4);
        check("mrst_head", bus.out_data, 32'hD4);
        check("mrst_count1", 32'(bus.count), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
